// File: rtl/ifu.sv
// ----------------------------------------------------------------------------
// ifu -- instruction fetch unit
//
// Holds the fetch PC and keeps at most one 32-bit fetch outstanding on the
// instruction memory port. Returned instructions are buffered with their PC
// in a QDEPTH-entry FIFO that feeds the decode stage. A redirect from execute
// flushes the FIFO and restarts fetch at the (word-aligned) target; a request
// already on the bus is allowed to complete and its response is discarded.
//
// Optional feature (macro IFU_RESP_BYPASS_EN):
//   defined   - with the FIFO empty, a live response is forwarded to decode in
//               the same cycle and is only buffered if decode does not take it.
//   undefined - decode outputs come only from FIFO registers.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   o_imem_req_valid    fetch request valid
//   i_imem_req_ready    memory accepts the request
//   o_imem_addr         fetch address (4-byte aligned)
//   i_imem_resp_valid   fetch response valid (one per accepted request)
//   i_imem_resp_data    fetched instruction
//   i_redirect          flush and restart fetch
//   i_redirect_pc       redirect target
//   o_valid             instruction available to decode
//   o_insn, o_pc        instruction and its PC
//   i_ready             decode consumes o_insn this cycle
// ----------------------------------------------------------------------------
module ifu #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_resp_valid,
    input  logic [31:0] i_imem_resp_data,
    input  logic        i_redirect,
    input  logic [63:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_insn,
    output logic [63:0] o_pc,
    input  logic        i_ready
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [63:0]      req_addr_q, req_addr_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]      fifo_insn_q [QDEPTH];
    logic [63:0]      fifo_pc_q   [QDEPTH];

    logic req_fire;
    logic resp_fire;
    logic head_valid;
    logic push;
    logic pop;
    logic space_ok;
    logic unused_redir_lsb;

    assign unused_redir_lsb = ^i_redirect_pc[1:0];

    assign req_fire   = o_imem_req_valid && i_imem_req_ready;
    assign resp_fire  = (state_q == ST_WAIT) && i_imem_resp_valid;
    assign head_valid = (cnt_q != '0);

`ifdef IFU_RESP_BYPASS_EN
    logic bypass_act;

    assign bypass_act = resp_fire && !drop_q && !i_redirect && !head_valid;
    // A bypassed response that decode takes immediately never enters the FIFO.
    assign push       = resp_fire && !drop_q && !i_redirect && !(bypass_act && i_ready);
    assign pop        = head_valid && i_ready && !i_redirect;
    assign o_valid    = head_valid || bypass_act;
    assign o_insn     = bypass_act ? i_imem_resp_data : fifo_insn_q[rd_ptr_q];
    assign o_pc       = bypass_act ? req_addr_q : fifo_pc_q[rd_ptr_q];
`else
    assign push       = resp_fire && !drop_q && !i_redirect;
    assign pop        = head_valid && i_ready && !i_redirect;
    assign o_valid    = head_valid;
    assign o_insn     = fifo_insn_q[rd_ptr_q];
    assign o_pc       = fifo_pc_q[rd_ptr_q];
`endif

    // Occupancy after this cycle's push/pop; a redirect empties the FIFO.
    always_comb begin
        cnt_d = cnt_q;
        if (i_redirect) begin
            cnt_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // With one fetch outstanding at most, a free slot now is a slot for its response.
    assign space_ok = (cnt_d < DEPTH_C);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (space_ok) state_d = ST_REQ;
            ST_REQ:  if (req_fire) state_d = ST_WAIT;
            ST_WAIT: if (i_imem_resp_valid) state_d = space_ok ? ST_REQ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_imem_req_valid = (state_q == ST_REQ);
    end

    assign o_imem_addr = req_addr_q;

    // PC, drop flag and the latched request address.
    always_comb begin
        pc_d       = pc_q;
        drop_d     = drop_q;
        req_addr_d = req_addr_q;
        // A stale request (drop set) must not advance the redirected PC.
        if ((state_q == ST_REQ) && req_fire && !drop_q) begin
            pc_d = pc_q + 64'd4;
        end
        if (resp_fire) begin
            drop_d = 1'b0;
        end
        if (i_redirect) begin
            pc_d = {i_redirect_pc[63:2], 2'b00};
            // The bus request cannot be retracted: its response must be discarded,
            // unless that response is arriving right now.
            if ((state_q == ST_REQ) || ((state_q == ST_WAIT) && !i_imem_resp_valid)) begin
                drop_d = 1'b1;
            end
        end
        // The address is frozen for the whole REQ phase.
        if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
            req_addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                fifo_insn_q[i] <= '0;
                fifo_pc_q[i]   <= RESET_PC;
            end
        end else begin
            if (push) begin
                fifo_insn_q[wr_ptr_q] <= i_imem_resp_data;
                fifo_pc_q[wr_ptr_q]   <= req_addr_q;
            end
            if (i_redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

    logic        clk;
    logic        rst_n;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [63:0] o_imem_addr;
    logic        i_imem_resp_valid;
    logic [31:0] i_imem_resp_data;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_insn;
    logic [63:0] o_pc;
    logic        i_ready;

    int checks = 0;
    int errors = 0;

    // scoreboard queues: expected request addresses and expected decode outputs
    logic [63:0] exp_addr[$];
    logic [63:0] exp_pc[$];
    logic [31:0] exp_insn[$];

    // memory model state
    logic [63:0] pend_addr[$];
    int          pend_due[$];
    int          cyc       = 0;
    int          allow     = 0;
    int          stall_cnt = 0;
    int          mem_k     = 1;

    ifu dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .o_imem_req_valid  (o_imem_req_valid),
        .i_imem_req_ready  (i_imem_req_ready),
        .o_imem_addr       (o_imem_addr),
        .i_imem_resp_valid (i_imem_resp_valid),
        .i_imem_resp_data  (i_imem_resp_data),
        .i_redirect        (i_redirect),
        .i_redirect_pc     (i_redirect_pc),
        .o_valid           (o_valid),
        .o_insn            (o_insn),
        .o_pc              (o_pc),
        .i_ready           (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_fetch(input logic [63:0] addr, input logic [31:0] insn);
        exp_addr.push_back(addr);
        exp_pc.push_back(addr);
        exp_insn.push_back(insn);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_valid"}, 64'(o_imem_req_valid), 64'd0);
        chk({tag, "_o_valid"},   64'(o_valid),          64'd0);
        chk({tag, "_addr"},      o_imem_addr,           64'h8000_0000);
        chk({tag, "_insn"},      64'(o_insn),           64'd0);
        chk({tag, "_pc"},        o_pc,                  64'h8000_0000);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_addr.size() != 0 || exp_pc.size() != 0) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (exp_addr.size() != 0 || exp_pc.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: outstanding addr=%0d out=%0d, required 0 0", tag, exp_addr.size(), exp_pc.size());
        end
    endtask

    task automatic wait_handshake(input string tag);
        int n;
        n = 0;
        while (exp_addr.size() != 0 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (exp_addr.size() != 0) begin
            errors++;
            $display("FAIL %s_handshake: pending requests %0d, required 0", tag, exp_addr.size());
        end
    endtask

    // memory model: drives ready/response at posedge+1, samples handshakes at negedge
    initial begin
        i_imem_req_ready  = 1'b0;
        i_imem_resp_valid = 1'b0;
        i_imem_resp_data  = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            i_imem_resp_valid = 1'b0;
            i_imem_resp_data  = '0;
            if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
                i_imem_resp_valid = 1'b1;
                i_imem_resp_data  = pend_addr[0][31:0] ^ 32'h1357_9BDF;
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (stall_cnt > 0) begin
                i_imem_req_ready = 1'b0;
                stall_cnt--;
            end else begin
                i_imem_req_ready = (allow > 0);
            end
            @(negedge clk);
            if (rst_n && o_imem_req_valid && i_imem_req_ready) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got addr %h, required no request", o_imem_addr);
                end else begin
                    chk("req_addr", o_imem_addr, exp_addr.pop_front());
                end
                allow--;
                pend_addr.push_back(o_imem_addr);
                pend_due.push_back(cyc + mem_k);
            end else if (rst_n && o_imem_req_valid && exp_addr.size() != 0) begin
                chk("req_addr_hold", o_imem_addr, exp_addr[0]);
            end
        end
    end

    // output monitor: compares every instruction handed to decode
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && o_valid && i_ready && !i_redirect) begin
                if (exp_pc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got pc=%h insn=%h, required none", o_pc, o_insn);
                end else begin
                    chk("out_pc",   o_pc,         exp_pc.pop_front());
                    chk("out_insn", 64'(o_insn),  64'(exp_insn.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        i_ready       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;

        // reset values, then straight-line fetch with k=1
        repeat (3) @(posedge clk);
        #2;
        check_reset("rst0");
        expect_fetch(64'h8000_0000, 32'h9357_9BDF);
        expect_fetch(64'h8000_0004, 32'h9357_9BDB);
        expect_fetch(64'h8000_0008, 32'h9357_9BD7);
        allow = 3;
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain("seq");

        // decode stalled: FIFO fills to two and fetch stops
        @(posedge clk); #2;
        i_ready = 1'b0;
        expect_fetch(64'h8000_000C, 32'h9357_9BD3);
        expect_fetch(64'h8000_0010, 32'h9357_9BCF);
        expect_fetch(64'h8000_0014, 32'h9357_9BCB);
        allow = 3;
        repeat (12) @(posedge clk);
        #2;
        chk("full_req_valid", 64'(o_imem_req_valid), 64'd0);
        chk("full_reqs_left", 64'(exp_addr.size()),  64'd1);
        chk("full_o_valid",   64'(o_valid),          64'd1);
        chk("full_head_pc",   o_pc,                  64'h8000_000C);
        i_ready = 1'b1;
        wait_drain("full");

        // reset while requesting, then hold ready low for 5 cycles on the second fetch
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst1");
        pend_addr.delete();
        pend_due.delete();
        allow = 1;
        expect_fetch(64'h8000_0000, 32'h9357_9BDF);
        expect_fetch(64'h8000_0004, 32'h9357_9BDB);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (exp_addr.size() != 1 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("stall_first_hs", 64'(exp_addr.size()), 64'd1);
        stall_cnt = 5;
        allow     = 1;
        wait_drain("stall");

        // redirect to a misaligned target while the fetch is in flight (k=3)
        @(posedge clk); #2;
        mem_k = 3;
        allow = 1;
        exp_addr.push_back(64'h8000_0008);
        wait_handshake("redir_wait");
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h8000_1002;
        @(posedge clk); #2;
        i_redirect = 1'b0;
        chk("redir_wait_o_valid", 64'(o_valid), 64'd0);
        expect_fetch(64'h8000_1000, 32'h9357_8BDF);
        allow = 1;
        wait_drain("redir_wait");

        // redirect in the same cycle as the response (k=1)
        @(posedge clk); #2;
        mem_k = 1;
        allow = 1;
        exp_addr.push_back(64'h8000_1004);
        n = 0;
        while (!i_imem_resp_valid && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("redir_resp_seen", 64'(i_imem_resp_valid), 64'd1);
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h8000_2000;
        expect_fetch(64'h8000_2000, 32'h9357_BBDF);
        allow = 1;
        @(posedge clk); #2;
        i_redirect = 1'b0;
        chk("redir_resp_o_valid", 64'(o_valid), 64'd0);
        wait_drain("redir_resp");

        // reset asserted mid-WAIT, fetch restarts at the reset PC
        @(posedge clk); #2;
        mem_k = 5;
        allow = 1;
        exp_addr.push_back(64'h8000_2004);
        wait_handshake("rst_wait");
        rst_n = 1'b0;
        #1;
        check_reset("rst2");
        pend_addr.delete();
        pend_due.delete();
        mem_k = 1;
        allow = 1;
        expect_fetch(64'h8000_0000, 32'h9357_9BDF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain("rst_restart");

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
